gd4_minimizer: RTL and testbench

- Fixed-point gradient-descent engine. It minimises the built-in 4-variable quadratic f(a,b,c,d) = (a-1)^2 + (b-2)^2 + (c-3)^2 + (d-4)^2, starting from user-supplied initial values.
- Runs until convergence or until NUM_ITERATIONS updates, then reports the final point and f at that point.
- Standalone top-level compute block with a level start/done handshake.

---
 rtl/gd4_minimizer.sv | 238 +++++++++++++++++++++++
 tb/tb_gd4_minimizer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gd4_minimizer.sv
// -----------------------------------------------------------------------------
// gd4_minimizer
//
// Fixed-point gradient-descent engine. It minimises the fixed quadratic
//   f(a,b,c,d) = (a-1)^2 + (b-2)^2 + (c-3)^2 + (d-4)^2
// starting from a user-supplied point. It stops when every step rounds to
// zero (converged) or after NUM_ITERATIONS updates, whichever comes first.
// It then reports the final point and f evaluated at that point.
//
// Parameters
//   NUM_ITERATIONS : maximum number of parameter updates per run (>= 1)
//   LEARNING_RATE  : step size, signed Q24.8
//
// Ports
//   clk                    : clock, all state on the rising edge
//   rst_n                  : asynchronous active-low reset
//   start_op               : level request, sampled only in IDLE
//   a/b/c/d_init   [15:0]  : signed Q8.8 starting point
//   z_min          [31:0]  : signed Q24.8, f at the final point
//   a/b/c/d_at_min [15:0]  : signed Q8.8 final point
//   done_op                : high while the result is presented (DONE state)
// -----------------------------------------------------------------------------
module gd4_minimizer #(
    parameter int          NUM_ITERATIONS = 50,
    parameter logic [31:0] LEARNING_RATE  = 32'h00000010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_op,
    input  logic [15:0] a_init,
    input  logic [15:0] b_init,
    input  logic [15:0] c_init,
    input  logic [15:0] d_init,
    output logic [31:0] z_min,
    output logic [15:0] a_at_min,
    output logic [15:0] b_at_min,
    output logic [15:0] c_at_min,
    output logic [15:0] d_at_min,
    output logic        done_op
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_GRAD   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_EVAL   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic signed [31:0] LR_S = LEARNING_RATE;

    // iter_count holds the number of updates completed before the current one,
    // so "iter_count + 1 == NUM_ITERATIONS" is the same test as this compare.
    localparam logic [15:0] ITER_LAST = 16'(NUM_ITERATIONS - 1);

    localparam logic signed [64:0] P_MAX = 65'sd32767;
    localparam logic signed [64:0] P_MIN = -65'sd32768;
    localparam logic signed [35:0] Z_MAX = 36'sd2147483647;
    localparam logic signed [35:0] Z_MIN = -36'sd2147483648;

    // Q8.8 target for coordinate idx: a->1.0, b->2.0, c->3.0, d->4.0
    function automatic logic signed [15:0] target(input int idx);
        return 16'(256 * (idx + 1));
    endfunction

    // ------------------------------------------------------------------ state
    logic [2:0]         state_q, state_d;
    logic signed [15:0] p_q [4];
    logic signed [15:0] p_d [4];
    logic signed [63:0] step_q [4];
    logic signed [63:0] step_d [4];
    logic [15:0]        iter_count, iter_count_d;
    logic               converged, converged_d;
    logic [31:0]        z_min_q, z_min_d;
    logic [15:0]        at_min_q [4];
    logic [15:0]        at_min_d [4];
    logic               done_op_q, done_op_d;

    // --------------------------------------------------------------- datapath
    logic signed [16:0] err [4];
    logic signed [31:0] grad [4];
    logic signed [63:0] prod [4];
    logic signed [63:0] step_calc [4];
    logic signed [64:0] diff [4];
    logic signed [15:0] p_sat [4];
    logic signed [33:0] sq [4];
    logic signed [35:0] sq_sum;
    logic signed [35:0] z_shift;
    logic [31:0]        z_sat;
    logic               steps_zero;

    // NOTE: every variable written here gets a value on every path (defaults
    // first), so this block infers pure combinational logic and no latches.
    always_comb begin : datapath
        steps_zero = 1'b1;
        sq_sum     = '0;
        for (int i = 0; i < 4; i++) begin
            // 17-bit difference cannot overflow for any 16-bit operands
            err[i]       = 17'(p_q[i]) - 17'(target(i));
            // 2*e, sign-extended to Q24.8
            grad[i]      = {{14{err[i][16]}}, err[i], 1'b0};
            prod[i]      = 64'(grad[i]) * 64'(LR_S);
            // arithmetic shift floors toward -inf, so approach from below
            // never overshoots while approach from above can stall
            step_calc[i] = prod[i] >>> 8;

            diff[i] = 65'(p_q[i]) - 65'(step_q[i]);
            if (diff[i] > P_MAX) begin
                p_sat[i] = 16'sh7FFF;
            end else if (diff[i] < P_MIN) begin
                p_sat[i] = -16'sh8000;
            end else begin
                p_sat[i] = diff[i][15:0];
            end

            if (step_q[i] != '0) begin
                steps_zero = 1'b0;
            end

            sq[i]  = 34'(err[i]) * 34'(err[i]);
            sq_sum = sq_sum + 36'(sq[i]);
        end

        // Q16.16 sum back to Q24.8
        z_shift = sq_sum >>> 8;
        if (z_shift > Z_MAX) begin
            z_sat = 32'h7FFF_FFFF;
        end else if (z_shift < Z_MIN) begin
            z_sat = 32'h8000_0000;
        end else begin
            z_sat = z_shift[31:0];
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin : next_state
        state_d      = state_q;
        p_d          = p_q;
        step_d       = step_q;
        iter_count_d = iter_count;
        converged_d  = converged;
        z_min_d      = z_min_q;
        at_min_d     = at_min_q;

        case (state_q)
            S_IDLE: begin
                if (start_op) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                p_d[0]       = a_init;
                p_d[1]       = b_init;
                p_d[2]       = c_init;
                p_d[3]       = d_init;
                iter_count_d = '0;
                converged_d  = 1'b0;
                z_min_d      = '0;
                for (int i = 0; i < 4; i++) begin
                    at_min_d[i] = '0;
                end
                state_d      = S_GRAD;
            end
            S_GRAD: begin
                step_d  = step_calc;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                p_d          = p_sat;
                iter_count_d = iter_count + 16'd1;
                if (steps_zero) begin
                    converged_d = 1'b1;
                    state_d     = S_EVAL;
                end else if (iter_count == ITER_LAST) begin
                    state_d = S_EVAL;
                end else begin
                    state_d = S_GRAD;
                end
            end
            S_EVAL: begin
                z_min_d = z_sat;
                for (int i = 0; i < 4; i++) begin
                    at_min_d[i] = p_q[i];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!start_op) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // registered so done_op is glitch-free and tracks the DONE state
        done_op_d = (state_d == S_DONE);
    end

    // -------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: the small working arrays are reset too, so an aborted run leaves
    // no partial result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            iter_count <= '0;
            converged  <= 1'b0;
            z_min_q    <= '0;
            done_op_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                p_q[i]      <= '0;
                step_q[i]   <= '0;
                at_min_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            iter_count <= iter_count_d;
            converged  <= converged_d;
            z_min_q    <= z_min_d;
            done_op_q  <= done_op_d;
            for (int i = 0; i < 4; i++) begin
                p_q[i]      <= p_d[i];
                step_q[i]   <= step_d[i];
                at_min_q[i] <= at_min_d[i];
            end
        end
    end

    assign z_min    = z_min_q;
    assign a_at_min = at_min_q[0];
    assign b_at_min = at_min_q[1];
    assign c_at_min = at_min_q[2];
    assign d_at_min = at_min_q[3];
    assign done_op  = done_op_q;

endmodule

// File: tb/tb_gd4_minimizer.sv
// -----------------------------------------------------------------------------
// tb_gd4_minimizer
//
// Self-checking bench for gd4_minimizer. Two instances share clock and reset:
// one with the default learning rate, one with 4.0 to exercise saturation.
// Expected results come from hand-derived vectors and from a plain-arithmetic
// model of the descent rules.
// -----------------------------------------------------------------------------
module tb_gd4_minimizer;

    localparam int          NUM_IT  = 50;
    localparam longint      LR_DEF  = 64'sd16;
    localparam longint      LR_SAT  = 64'sd1024;
    localparam longint      Z_HI    = 64'sd2147483647;
    localparam longint      Z_LO    = -64'sd2147483648;
    localparam logic [63:0] AT_TGT  = 64'h0100_0200_0300_0400;
    localparam logic [63:0] ALL_127 = 64'h7F00_7F00_7F00_7F00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [63:0] init0, init1;
    logic [31:0] z0, z1;
    logic [15:0] am0, bm0, cm0, dm0, am1, bm1, cm1, dm1;
    logic        done0, done1;
    logic [63:0] fin0, fin1;

    assign fin0 = {am0, bm0, cm0, dm0};
    assign fin1 = {am1, bm1, cm1, dm1};

    always #5 clk = ~clk;

    gd4_minimizer #(.NUM_ITERATIONS(NUM_IT), .LEARNING_RATE(32'h0000_0010)) dut (
        .clk(clk), .rst_n(rst_n), .start_op(start0),
        .a_init(init0[63:48]), .b_init(init0[47:32]),
        .c_init(init0[31:16]), .d_init(init0[15:0]),
        .z_min(z0), .a_at_min(am0), .b_at_min(bm0), .c_at_min(cm0), .d_at_min(dm0),
        .done_op(done0)
    );

    gd4_minimizer #(.NUM_ITERATIONS(NUM_IT), .LEARNING_RATE(32'h0000_0400)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start_op(start1),
        .a_init(init1[63:48]), .b_init(init1[47:32]),
        .c_init(init1[31:16]), .d_init(init1[15:0]),
        .z_min(z1), .a_at_min(am1), .b_at_min(bm1), .c_at_min(cm1), .d_at_min(dm1),
        .done_op(done1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: descend with floor-rounded steps until all steps are zero
    // or NUM_IT updates have been made, then evaluate f at the final point.
    function automatic void model(input logic [63:0] init, input longint lr,
                                  output logic [63:0] fin, output int n,
                                  output bit conv, output logic [31:0] z);
        longint p [4];
        longint s [4];
        longint e;
        longint sum;
        bit     zero;
        for (int i = 0; i < 4; i++) p[i] = longint'($signed(init[63-16*i -: 16]));
        n    = 0;
        conv = 1'b0;
        while (1) begin
            zero = 1'b1;
            for (int i = 0; i < 4; i++) begin
                e    = p[i] - 256 * (i + 1);
                s[i] = (2 * e * lr) >>> 8;
                if (s[i] != 0) zero = 1'b0;
            end
            for (int i = 0; i < 4; i++) p[i] = clamp(p[i] - s[i], -32768, 32767);
            n++;
            if (zero) begin
                conv = 1'b1;
                break;
            end
            if (n == NUM_IT) break;
        end
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            e   = p[i] - 256 * (i + 1);
            sum = sum + e * e;
        end
        z   = 32'(clamp(sum >>> 8, Z_LO, Z_HI));
        fin = {16'(p[0]), 16'(p[1]), 16'(p[2]), 16'(p[3])};
    endfunction

    // Starts a run on one instance, optionally drops start_op at cycle drop_at,
    // waits (bounded) for done_op and checks that done_op falls one cycle
    // after start_op is low. lat counts edges from the sampling edge.
    task automatic run_dut(input string tag, input bit sel, input logic [63:0] init,
                           input int drop_at, output int lat, output logic [63:0] fin,
                           output logic [31:0] z, output int iters, output bit conv);
        bit seen;
        @(negedge clk);
        if (sel) begin
            init1  = init;
            start1 = 1'b1;
        end else begin
            init0  = init;
            start0 = 1'b1;
        end
        lat  = 0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 300 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == drop_at) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            if ((sel ? done1 : done0) === 1'b1) begin
                seen = 1'b1;
                lat  = cyc;
            end
        end
        check({tag, "/done_seen"}, 64'(seen), 64'd1);
        fin   = sel ? fin1 : fin0;
        z     = sel ? z1 : z0;
        iters = sel ? int'(dut_sat.iter_count) : int'(dut.iter_count);
        conv  = sel ? dut_sat.converged : dut.converged;
        start0 = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        check({tag, "/done_drop"}, 64'(sel ? done1 : done0), 64'd0);
    endtask

    task automatic check_model(input string tag, input logic [63:0] init, input longint lr,
                               input int lat, input logic [63:0] fin, input logic [31:0] z,
                               input int iters, input bit conv);
        logic [63:0] m_fin;
        int          m_n;
        bit          m_conv;
        logic [31:0] m_z;
        model(init, lr, m_fin, m_n, m_conv, m_z);
        check({tag, "/point"}, fin, m_fin);
        check({tag, "/z"}, 64'(z), 64'(m_z));
        check({tag, "/iter"}, 64'(iters), 64'(m_n));
        check({tag, "/conv"}, 64'(conv), 64'(m_conv));
        check({tag, "/latency"}, 64'(lat), 64'(2 * m_n + 3));
    endtask

    typedef struct {
        logic [63:0] init;
        int          exp_iter;
        bit          exp_conv;
        logic [31:0] exp_z;
        logic [63:0] exp_fin;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          lat, iters;
        bit          conv;
        logic [63:0] fin, init;
        logic [31:0] z;
        bit          ok, seen;
        int          drop;

        // hand-derived convergence vectors (default learning rate 1/16)
        vecs[0] = '{AT_TGT,                 1, 1'b1, 32'd0, AT_TGT,                 5};
        vecs[1] = '{64'h0100_0200_0300_0407, 1, 1'b1, 32'd0, 64'h0100_0200_0300_0407, 5};
        vecs[2] = '{64'h0100_0200_0300_0408, 2, 1'b1, 32'd0, 64'h0100_0200_0300_0407, 7};
        vecs[3] = '{64'h0100_0200_0300_03FF, 2, 1'b1, 32'd0, AT_TGT,                 7};
        vecs[4] = '{64'h0100_0200_0300_03F0, 13, 1'b1, 32'd0, AT_TGT,                29};
        vecs[5] = '{64'h0110_0200_0300_0400, 9, 1'b1, 32'd0, 64'h0107_0200_0300_0400, 21};

        // ---- reset held with start_op high
        rst_n  = 1'b0;
        start0 = 1'b1;
        start1 = 1'b0;
        init0  = AT_TGT;
        init1  = '0;
        #23;
        check("rst/done", 64'(done0), 64'd0);
        check("rst/z", 64'(z0), 64'd0);
        check("rst/point", fin0, 64'd0);
        check("rst/iter", 64'(dut.iter_count), 64'd0);
        check("rst/conv", 64'(dut.converged), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        lat   = 0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                seen = 1'b1;
                lat  = cyc;
            end
        end
        check("rst_release/latency", 64'(lat), 64'd5);
        check("rst_release/point", fin0, AT_TGT);
        start0 = 1'b0;
        @(negedge clk);
        check("rst_release/done_drop", 64'(done0), 64'd0);

        // ---- table-driven vectors
        for (int v = 0; v < 6; v++) begin
            run_dut($sformatf("vec%0d", v), 1'b0, vecs[v].init, -1, lat, fin, z, iters, conv);
            check($sformatf("vec%0d/point", v), fin, vecs[v].exp_fin);
            check($sformatf("vec%0d/z", v), 64'(z), 64'(vecs[v].exp_z));
            check($sformatf("vec%0d/iter", v), 64'(iters), 64'(vecs[v].exp_iter));
            check($sformatf("vec%0d/conv", v), 64'(conv), 64'(vecs[v].exp_conv));
            check($sformatf("vec%0d/latency", v), 64'(lat), 64'(vecs[v].exp_lat));
        end

        // ---- worst case from 127.0 on all four
        run_dut("max", 1'b0, ALL_127, -1, lat, fin, z, iters, conv);
        check_model("max", ALL_127, LR_DEF, lat, fin, z, iters, conv);
        check("max/iter50", 64'(iters), 64'd50);
        check("max/not_conv", 64'(conv), 64'd0);
        check("max/lat103", 64'(lat), 64'd103);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("max/int_part%0d", i), 64'(fin[63-16*i -: 8]), 64'(i + 1));
            ok = (int'(fin[63-16*i -: 16]) - 256 * (i + 1) >= 0) &&
                 (int'(fin[63-16*i -: 16]) - 256 * (i + 1) <= 76);
            check($sformatf("max/within_0p3_%0d", i), 64'(ok), 64'd1);
        end
        check("max/z_range", 64'((z > 0) && (z < 32'h20)), 64'd1);

        // ---- sweep 127 - 15k
        for (int k = 0; k < 16; k++) begin
            init = {4{16'(32'h7F00 - 15 * 256 * k)}};
            run_dut($sformatf("sweep%0d", k), 1'b0, init, -1, lat, fin, z, iters, conv);
            check_model($sformatf("sweep%0d", k), init, LR_DEF, lat, fin, z, iters, conv);
            ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (fin[63-16*i -: 16] == 16'h8000 || fin[63-16*i -: 16] == 16'h7FFF) ok = 1'b0;
                if (abs_i(int'($signed(fin[63-16*i -: 16])) - 256 * (i + 1)) >
                    abs_i(int'($signed(init[63-16*i -: 16])) - 256 * (i + 1))) ok = 1'b0;
            end
            check($sformatf("sweep%0d/approach_nosat", k), 64'(ok), 64'd1);
        end

        // ---- random points, start_op dropped mid-run
        for (int r = 0; r < 8; r++) begin
            init = {$urandom(), $urandom()};
            drop = int'($urandom_range(1, 30));
            run_dut($sformatf("rand%0d", r), 1'b0, init, drop, lat, fin, z, iters, conv);
            check_model($sformatf("rand%0d", r), init, LR_DEF, lat, fin, z, iters, conv);
        end

        // ---- saturation with learning rate 4.0: ping-pong between the rails
        run_dut("sat", 1'b1, ALL_127, -1, lat, fin, z, iters, conv);
        check_model("sat", ALL_127, LR_SAT, lat, fin, z, iters, conv);
        check("sat/rails", fin, 64'h7FFF_7FFF_7FFF_7FFF);

        // ---- asynchronous reset at iteration 10
        @(negedge clk);
        init0  = ALL_127;
        start0 = 1'b1;
        seen   = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            if (dut.iter_count == 16'd10) seen = 1'b1;
        end
        check("midrst/reached_iter10", 64'(seen), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst/done", 64'(done0), 64'd0);
        check("midrst/z", 64'(z0), 64'd0);
        check("midrst/point", fin0, 64'd0);
        check("midrst/iter", 64'(dut.iter_count), 64'd0);
        check("midrst/conv", 64'(dut.converged), 64'd0);
        start0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_dut("fresh", 1'b0, ALL_127, -1, lat, fin, z, iters, conv);
        check_model("fresh", ALL_127, LR_DEF, lat, fin, z, iters, conv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
